hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (Fetch/Decode/Execute/Memory/Writeback). It generates operand forwarding selects, stage stall and flush controls, and squashes on taken branches and jumps. It adds configurable data-memory latency: a fixed-latency wait-state FSM freezes the whole pipe while a load or store completes. It also adds a no-forwarding mode and saturating stall and flush performance counters. It sits beside the stage tops in `cpu`, taking register indices and control bits from the pipeline registers and driving their enable and clear inputs.

## Interface

**Parameters**

- `REG_AW`, default 5. Register-index width.
- `DMEM_LATENCY`, default 1. Cycles a memory access occupies the M stage (≥1). A value of 1 means no wait states.
- `FWD_ENABLE`, default 1. 1 selects forwarding. 0 disables forwarding and stalls on every RAW hazard.
- `CNT_W`, default 32. Width of the performance counters.

**Ports**

- Reset is synchronous and active-high: `rst` is sampled on the rising edge of `clk`. There is one clock.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `Rs1D`, `Rs2D`  in  REG_AW  source registers in D.
- `Rs1E`, `Rs2E`  in  REG_AW  source registers in E.
- `RdE`, `RdM`, `RdW`  in  REG_AW  destination registers in E, M and W.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1  register-write enables per stage.
- `ResultSrcE`  in  2  result select in E; `2'b01` means a load.
- `PCSrcE`  in  1  taken branch or jump resolved in E.
- `MemReqM`  in  1  load or store present in M.
- `CntClr`  in  1  synchronous clear of both counters.
- `ForwardAE`, `ForwardBE`  out  2  `00` = register file, `10` = ALUResultM, `01` = ResultW.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW`  out  1  hold the pipeline register feeding each stage.
- `FlushD`, `FlushE`  out  1  clear the D or E pipeline register to a bubble.
- `MemBusy`  out  1  memory wait state active.
- `StallCnt`, `FlushCnt`  out  CNT_W  saturating event counters.

## Operation

**Forwarding (FWD_ENABLE=1)**

- ForwardAE = `10` if `RegWriteM && RdM!=0 && RdM==Rs1E`.
- Otherwise ForwardAE = `01` if `RegWriteW && RdW!=0 && RdW==Rs1E`.
- Otherwise ForwardAE = `00`.
- M has priority over W. x0 is never forwarded.
- ForwardBE uses the same rules with `Rs2E`.

**Load-use hazard (FWD_ENABLE=1)**

- Condition: `ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)`.
- Response: StallF=StallD=1 and FlushE=1, giving one bubble.

**No-forward mode (FWD_ENABLE=0)**

- ForwardAE and ForwardBE are fixed at `00`.
- RAW hazard: `Rs1D` or `Rs2D` is nonzero and matches `RdE` (with `RegWriteE`) or `RdM` (with `RegWriteM`).
- Response: StallF=StallD=1 and FlushE=1, repeated each cycle until the hazard clears.
- W-stage matches need no stall, because the register file writes through.

**Control hazard**

- When PCSrcE=1: FlushD=FlushE=1.
- Any load-use or RAW stall in the same cycle is cancelled (StallF=StallD=0), because the D instruction is squashed.

**Memory wait FSM**

- State is held in `wait_cnt`, range 0..DMEM_LATENCY-1. IDLE means wait_cnt=0. BUSY means wait_cnt>0.
- `mem_stall = MemReqM && (wait_cnt != DMEM_LATENCY-1)`.
- When mem_stall is 1, wait_cnt increments. When mem_stall is 0, wait_cnt resets to 0.
- While mem_stall=1:
  - all five Stall outputs are 1 and the whole pipe freezes, preserving W forwarding;
  - FlushD=FlushE=0, and load-use, RAW and branch responses are suppressed. These conditions are re-evaluated on the release cycle.
- MemBusy = mem_stall.
- With DMEM_LATENCY=1, mem_stall is constantly 0.

**Counters**

- StallCnt increments on every cycle with StallF=1.
- FlushCnt increments on every cycle with FlushD=1 caused by PCSrcE.
- Both saturate at all-ones.
- CntClr=1 clears both counters and takes priority over increment.

## Timing

- Forwarding, stall and flush outputs are combinational from inputs and `wait_cnt`, with zero-cycle latency.
- Counters and `wait_cnt` update on the rising edge of `clk`.
- During rst:
  - Stall* = 0, Forward* = `00`, FlushD = FlushE = 1, MemBusy = 0;
  - after the edge, wait_cnt = 0 and StallCnt = FlushCnt = 0.
- Reset asserted mid-wait aborts the wait: wait_cnt = 0 on the next cycle.
- A memory access stalls for exactly DMEM_LATENCY-1 cycles, then advances on the cycle wait_cnt reaches DMEM_LATENCY-1.
- Back-to-back memory ops: the second op starts at wait_cnt=0 and stalls another DMEM_LATENCY-1 cycles, with no gap cycle.
- Simultaneous load-use and PCSrcE: the flush wins, and StallCnt does not increment.

## Test plan

1. **Forwarding priority.** FWD_ENABLE=1; RdM=RdW=Rs1E=5 with RegWriteM=RegWriteW=1 → ForwardAE=`10`. With Rs1E=0 → `00`.
2. **Load-use stall.** ResultSrcE=`01`, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle; StallCnt goes from 0 to 1.
3. **Branch over load-use.** Case 2 plus PCSrcE=1 → FlushD=FlushE=1, StallF=0; FlushCnt=1 and StallCnt=0.
4. **Memory wait, DMEM_LATENCY=3.** MemReqM held high → MemBusy/Stall* high for 2 cycles and low on the 3rd. A second MemReqM immediately after → 2 more stall cycles. PCSrcE=1 during the wait produces no flush until release.
5. **No-forward mode.** FWD_ENABLE=0; RdE=3 with RegWriteE and Rs1D=3 → stall. Next cycle RdM=3 → stall again. Then RdW=3 only → no stall, with Forward* always `00`.
6. **Reset and counters.** rst asserted mid-wait → wait_cnt=0 and MemBusy=0 next cycle. CNT_W=4 with 20 stall cycles → StallCnt=15 (saturated). CntClr → 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core.
// Drives operand forwarding selects, per-stage stalls and flushes, the
// data-memory wait-state stall and saturating stall/flush event counters.
//
// Memory wait FSM (state held in waitCnt):
//   state | meaning
//   IDLE  | waitCnt == 0, no access in progress or access on its first cycle
//   BUSY  | waitCnt  > 0, access still occupying M, whole pipe frozen
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DMEM_LATENCY = 1,
  parameter int FWD_ENABLE   = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MemBusy,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int WAIT_W = (DMEM_LATENCY > 1) ? $clog2(DMEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_LATENCY - 1);

  logic [WAIT_W-1:0] waitCnt;
  logic              memStall;
  logic              loadUse;
  logic              rawNoFwd;
  logic              dataHaz;
  logic              branchFlush;

  // Forward select for one E-stage source; M beats W, x0 never forwarded.
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs,
                                        input logic              wrM,
                                        input logic [REG_AW-1:0] rdM,
                                        input logic              wrW,
                                        input logic [REG_AW-1:0] rdW);
    logic [1:0] sel;
    sel = 2'b00;
    if (wrM && (rdM != '0) && (rdM == rs))      sel = 2'b10;
    else if (wrW && (rdW != '0) && (rdW == rs)) sel = 2'b01;
    return sel;
  endfunction

  // Hazard detection; reset forces the wait stall low so the pipe sees a clean flush.
  always_comb begin
    memStall = !rst && MemReqM && (waitCnt != WAIT_LAST);
    loadUse  = (ResultSrcE == 2'b01) && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
    rawNoFwd = ((Rs1D != '0) && ((RegWriteE && (RdE == Rs1D)) ||
                                 (RegWriteM && (RdM == Rs1D)))) ||
               ((Rs2D != '0) && ((RegWriteE && (RdE == Rs2D)) ||
                                 (RegWriteM && (RdM == Rs2D))));
    dataHaz  = (FWD_ENABLE != 0) ? loadUse : rawNoFwd;
    branchFlush = !rst && !memStall && PCSrcE;
  end

  // Forwarding, stall and flush outputs; the memory freeze overrides everything else.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    MemBusy   = memStall;
    if (!rst && (FWD_ENABLE != 0)) begin
      ForwardAE = fwdSel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwdSel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (PCSrcE) begin
      // The D instruction is squashed, so any stall for it is pointless.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (dataHaz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Wait-state counter: counts through the access, drops to 0 on the advancing cycle.
  always_ff @(posedge clk) begin
    if (rst)           waitCnt <= '0;
    else if (memStall) waitCnt <= waitCnt + WAIT_W'(1);
    else               waitCnt <= '0;
  end

  // Saturating performance counters; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1))      StallCnt <= StallCnt + CNT_W'(1);
      if (branchFlush && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: dutA has forwarding, 3-cycle memory and
// 4-bit counters; dutB has no forwarding and single-cycle memory.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReqM, CntClr;

  logic [1:0] aFA, aFB, bFA, bFB;
  logic aSF, aSD, aSE, aSM, aSW, aFD, aFE, aBusy;
  logic bSF, bSD, bSE, bSM, bSW, bFD, bFE, bBusy;
  logic [3:0] aSC, aFC, bSC, bFC;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .DMEM_LATENCY(3), .FWD_ENABLE(1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .CntClr(CntClr), .ForwardAE(aFA), .ForwardBE(aFB), .StallF(aSF), .StallD(aSD),
    .StallE(aSE), .StallM(aSM), .StallW(aSW), .FlushD(aFD), .FlushE(aFE),
    .MemBusy(aBusy), .StallCnt(aSC), .FlushCnt(aFC));

  hazard_ctrl #(.REG_AW(5), .DMEM_LATENCY(1), .FWD_ENABLE(0), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .CntClr(CntClr), .ForwardAE(bFA), .ForwardBE(bFB), .StallF(bSF), .StallD(bSD),
    .StallE(bSE), .StallM(bSM), .StallW(bSW), .FlushD(bFD), .FlushE(bFE),
    .MemBusy(bBusy), .StallCnt(bSC), .FlushCnt(bFC));

  typedef struct {
    string      nm;
    bit         dut;   // 0 = dutA, 1 = dutB
    logic [1:0] fa, fb;
    logic [4:0] st;    // {F,D,E,M,W}
    logic       fd, fe, busy;
    bit         chk;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic push(input string nm, input bit dut, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [4:0] st, input logic fd,
                      input logic fe, input logic busy, input bit chk,
                      input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.nm = nm; e.dut = dut; e.fa = fa; e.fb = fb; e.st = st;
    e.fd = fd; e.fe = fe; e.busy = busy; e.chk = chk; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  // Monitor: samples mid-cycle and retires every expectation queued for this cycle.
  initial begin
    exp_t e;
    logic [11:0] act, req;
    logic [7:0]  actC, reqC;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 1'b0) begin
          act  = {aFA, aFB, aSF, aSD, aSE, aSM, aSW, aFD, aFE, aBusy};
          actC = {aSC, aFC};
        end else begin
          act  = {bFA, bFB, bSF, bSD, bSE, bSM, bSW, bFD, bFE, bBusy};
          actC = {bSC, bFC};
        end
        req  = {e.fa, e.fb, e.st, e.fd, e.fe, e.busy};
        reqC = {e.sc, e.fc};
        nTests++;
        if (act !== req || (e.chk && actC !== reqC)) begin
          nFail++;
          $display("FAIL %s dut%0d: got fa/fb/stall/fd/fe/busy=%b cnt=%h, want %b cnt=%h",
                   e.nm, e.dut, act, actC, req, e.chk ? reqC : actC);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    PCSrcE = 0; MemReqM = 0; CntClr = 0;
  endtask

  task automatic loadUse(input logic [4:0] rd);
    ResultSrcE = 2'b01; RdE = rd; Rs2D = rd;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();

    // Reset: outputs forced regardless of hazardous inputs
    MemReqM = 1; PCSrcE = 1; RegWriteM = 1; RdM = 5; Rs1E = 5; loadUse(7);
    push("reset_outputs", 0, 2'b00, 2'b00, 5'b00000, 1, 1, 0, 1, 4'd0, 4'd0);
    push("reset_outputs", 1, 2'b00, 2'b00, 5'b00000, 1, 1, 0, 1, 4'd0, 4'd0);
    step();
    rst = 1'b0;

    // Forwarding priority and x0
    idle(); RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 5; Rs1E = 5;
    push("fwd_m_priority", 0, 2'b10, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd0, 4'd0);
    push("nofwd_fixed00", 1, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    step();
    Rs1E = 0; Rs2E = 5;
    push("fwd_b_m", 0, 2'b00, 2'b10, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    step();
    RegWriteM = 0; Rs1E = 5;
    push("fwd_w_only", 0, 2'b01, 2'b01, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    step();
    RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0; Rs2E = 0;
    push("fwd_x0_never", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    step();

    // Load-use stall (dutB sees the same pair as an E-stage RAW)
    idle(); loadUse(7); RegWriteE = 1;
    push("load_use", 0, 2'b00, 2'b00, 5'b11000, 0, 1, 0, 1, 4'd0, 4'd0);
    push("raw_e_nofwd", 1, 2'b00, 2'b00, 5'b11000, 0, 1, 0, 0, 4'd0, 4'd0);
    step();
    idle(); CntClr = 1;
    push("stallcnt_1", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd1, 4'd0);
    step();

    // Branch over load-use
    idle(); loadUse(7); PCSrcE = 1;
    push("branch_wins", 0, 2'b00, 2'b00, 5'b00000, 1, 1, 0, 1, 4'd0, 4'd0);
    step();
    idle();
    push("branch_counts", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd0, 4'd1);
    step();

    // Memory wait, latency 3, branch held during the wait, back-to-back op
    MemReqM = 1; PCSrcE = 1;
    push("mem_wait0", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 1, 4'd0, 4'd1);
    push("mem_lat1_nostall", 1, 2'b00, 2'b00, 5'b00000, 1, 1, 0, 0, 4'd0, 4'd0);
    step();
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    push("mem_wait1", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 1, 4'd1, 4'd1);
    step();
    ResultSrcE = 2'b00; RdE = 0; Rs1D = 0;
    push("mem_release_flush", 0, 2'b00, 2'b00, 5'b00000, 1, 1, 0, 1, 4'd2, 4'd1);
    step();
    PCSrcE = 0;
    push("mem_b2b_wait0", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 1, 4'd2, 4'd2);
    step();
    push("mem_b2b_wait1", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 1, 4'd3, 4'd2);
    step();
    push("mem_b2b_release", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd4, 4'd2);
    step();
    idle();
    push("mem_after", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd4, 4'd2);
    step();

    // No-forward mode: E match, M match, W-only match
    idle(); RegWriteE = 1; RdE = 3; Rs1D = 3; Rs1E = 3;
    push("nofwd_raw_e", 1, 2'b00, 2'b00, 5'b11000, 0, 1, 0, 0, 4'd0, 4'd0);
    step();
    RegWriteE = 0; RdE = 0; RegWriteM = 1; RdM = 3;
    push("nofwd_raw_m", 1, 2'b00, 2'b00, 5'b11000, 0, 1, 0, 0, 4'd0, 4'd0);
    push("fwd_m_same", 0, 2'b10, 2'b00, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    step();
    RegWriteM = 0; RdM = 0; RegWriteW = 1; RdW = 3;
    push("nofwd_w_nostall", 1, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    push("fwd_w_same", 0, 2'b01, 2'b00, 5'b00000, 0, 0, 0, 0, 4'd0, 4'd0);
    step();

    // Reset mid-wait aborts the access
    idle(); MemReqM = 1;
    push("rst_pre_wait", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 0, 4'd0, 4'd0);
    step();
    rst = 1;
    push("rst_mid_wait", 0, 2'b00, 2'b00, 5'b00000, 1, 1, 0, 0, 4'd0, 4'd0);
    step();
    rst = 0;
    push("rst_wait_restart0", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 1, 4'd0, 4'd0);
    step();
    push("rst_wait_restart1", 0, 2'b00, 2'b00, 5'b11111, 0, 0, 1, 1, 4'd1, 4'd0);
    step();
    CntClr = 1;
    push("rst_wait_release", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd2, 4'd0);
    step();

    // Saturation: 20 load-use stalls into a 4-bit counter
    idle();
    for (int i = 0; i < 20; i++) begin
      loadUse(9);
      if (i == 0) push("sat_start", 0, 2'b00, 2'b00, 5'b11000, 0, 1, 0, 1, 4'd0, 4'd0);
      step();
    end
    idle();
    push("stallcnt_saturated", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd15, 4'd0);
    step();
    CntClr = 1; loadUse(9);
    push("cntclr_priority", 0, 2'b00, 2'b00, 5'b11000, 0, 1, 0, 1, 4'd15, 4'd0);
    step();
    idle();
    push("cntclr_zero", 0, 2'b00, 2'b00, 5'b00000, 0, 0, 0, 1, 4'd0, 4'd0);
    step();

    step();
    step();
    if (q.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
